// File: rtl/dfr_core_controller.sv
// Run sequencer for the DFR core: walks INIT, TRAIN and TEST phases, drives reservoir
// stepping and history writes, and launches the dot-product engine after every TEST sample.
module dfr_core_controller #(
  parameter int RESERVOIR_DATA_WIDTH         = 32,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16,
  parameter int INPUT_MEM_ADDR_WIDTH         = 16,
  parameter int OUTPUT_MEM_ADDR_WIDTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [31:0]                             num_init_steps,
  input  logic [31:0]                             num_train_steps,
  input  logic [31:0]                             num_test_samples,
  input  logic [31:0]                             num_steps_per_sample,
  output logic                                    busy,
  output logic                                    done,
  output logic [INPUT_MEM_ADDR_WIDTH-1:0]         input_mem_addr,
  output logic                                    reservoir_en,
  output logic                                    history_wen,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] history_addr,
  output logic                                    dp_start,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] dp_base_addr,
  input  logic                                    dp_done,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         dp_result,
  output logic                                    output_mem_wen,
  output logic [OUTPUT_MEM_ADDR_WIDTH-1:0]        output_mem_addr,
  output logic [RESERVOIR_DATA_WIDTH-1:0]         output_mem_data
);

  localparam int DW  = RESERVOIR_DATA_WIDTH;
  localparam int HAW = RESERVOIR_HISTORY_ADDR_WIDTH;
  localparam int IAW = INPUT_MEM_ADDR_WIDTH;
  localparam int OAW = OUTPUT_MEM_ADDR_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_TRAIN    = 3'd2;
  localparam logic [2:0] S_TEST     = 3'd3;
  localparam logic [2:0] S_DP_START = 3'd4;
  localparam logic [2:0] S_DP_WAIT  = 3'd5;
  localparam logic [2:0] S_OUT_WR   = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]     state_q, state_d;
  logic           start_d_q;
  logic           busy_q, busy_d, done_q, done_d;
  logic           res_en_q, res_en_d, hwen_q, hwen_d;
  logic           dps_q, dps_d, owen_q, owen_d;
  logic [IAW-1:0] in_addr_q, in_addr_d;
  logic [HAW-1:0] haddr_q, haddr_d, base_q, base_d;
  logic [OAW-1:0] oaddr_q, oaddr_d;
  logic [DW-1:0]  odata_q, odata_d;
  logic [31:0]    gstep_q, gstep_d, pstep_q, pstep_d, sstep_q, sstep_d, samp_q, samp_d;
  logic [HAW-1:0] hptr_q, hptr_d;
  logic [2:0]     after_train, after_init, after_idle;

  // ">=" rather than "==" so a count lowered mid-run still terminates the phase.
  function automatic logic is_last(input logic [31:0] cnt, input logic [31:0] total);
    return ({1'b0, cnt} + 33'd1) >= {1'b0, total};
  endfunction

  assign after_train = (num_test_samples != 32'd0 && num_steps_per_sample != 32'd0) ? S_TEST : S_DONE;
  assign after_init  = (num_train_steps != 32'd0) ? S_TRAIN : after_train;
  assign after_idle  = (num_init_steps != 32'd0) ? S_INIT : after_init;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_en_d  = 1'b0;
    hwen_d    = 1'b0;
    dps_d     = 1'b0;
    owen_d    = 1'b0;
    in_addr_d = in_addr_q;
    haddr_d   = haddr_q;
    base_d    = base_q;
    oaddr_d   = oaddr_q;
    odata_d   = odata_q;
    gstep_d   = gstep_q;
    pstep_d   = pstep_q;
    sstep_d   = sstep_q;
    samp_d    = samp_q;
    hptr_d    = hptr_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_d_q) begin
          gstep_d = '0;
          pstep_d = '0;
          sstep_d = '0;
          samp_d  = '0;
          hptr_d  = '0;
          busy_d  = 1'b1;
          state_d = after_idle;
        end
      end
      S_INIT, S_TRAIN: begin
        res_en_d  = 1'b1;
        in_addr_d = gstep_q[IAW-1:0];
        gstep_d   = gstep_q + 32'd1;
        if (state_q == S_TRAIN) begin
          hwen_d  = 1'b1;
          haddr_d = hptr_q;
          hptr_d  = hptr_q + HAW'(1);
        end
        if (is_last(pstep_q, (state_q == S_INIT) ? num_init_steps : num_train_steps)) begin
          pstep_d = '0;
          state_d = (state_q == S_INIT) ? after_init : after_train;
        end else begin
          pstep_d = pstep_q + 32'd1;
        end
      end
      S_TEST: begin
        res_en_d  = 1'b1;
        hwen_d    = 1'b1;
        in_addr_d = gstep_q[IAW-1:0];
        haddr_d   = hptr_q;
        gstep_d   = gstep_q + 32'd1;
        hptr_d    = hptr_q + HAW'(1);
        if (sstep_q == 32'd0) base_d = hptr_q;
        if (is_last(sstep_q, num_steps_per_sample)) begin
          sstep_d = '0;
          state_d = S_DP_START;
        end else begin
          sstep_d = sstep_q + 32'd1;
        end
      end
      S_DP_START: begin
        dps_d   = 1'b1;
        state_d = S_DP_WAIT;
      end
      S_DP_WAIT: begin
        // A dp_done coincident with the launch pulse belongs to no request of ours.
        if (dp_done && !dps_q) begin
          odata_d = dp_result;
          oaddr_d = samp_q[OAW-1:0];
          state_d = S_OUT_WR;
        end
      end
      S_OUT_WR: begin
        owen_d  = 1'b1;
        samp_d  = samp_q + 32'd1;
        state_d = is_last(samp_q, num_test_samples) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    start_d_q <= start;
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_en_q  <= 1'b0;
      hwen_q    <= 1'b0;
      dps_q     <= 1'b0;
      owen_q    <= 1'b0;
      in_addr_q <= '0;
      haddr_q   <= '0;
      base_q    <= '0;
      oaddr_q   <= '0;
      odata_q   <= '0;
      gstep_q   <= '0;
      pstep_q   <= '0;
      sstep_q   <= '0;
      samp_q    <= '0;
      hptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_en_q  <= res_en_d;
      hwen_q    <= hwen_d;
      dps_q     <= dps_d;
      owen_q    <= owen_d;
      in_addr_q <= in_addr_d;
      haddr_q   <= haddr_d;
      base_q    <= base_d;
      oaddr_q   <= oaddr_d;
      odata_q   <= odata_d;
      gstep_q   <= gstep_d;
      pstep_q   <= pstep_d;
      sstep_q   <= sstep_d;
      samp_q    <= samp_d;
      hptr_q    <= hptr_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign reservoir_en    = res_en_q;
  assign history_wen     = hwen_q;
  assign dp_start        = dps_q;
  assign output_mem_wen  = owen_q;
  assign input_mem_addr  = in_addr_q;
  assign history_addr    = haddr_q;
  assign dp_base_addr    = base_q;
  assign output_mem_addr = oaddr_q;
  assign output_mem_data = odata_q;

endmodule

// File: tb/tb_dfr_core_controller.sv
// Scoreboard bench for dfr_core_controller: a phase-level model queues expected steps,
// launches and output writes; a negedge monitor pops and compares as the DUT presents them.
module tb_dfr_core_controller;
  localparam int DW  = 32;
  localparam int HAW = 16;
  localparam int IMW = 4;
  localparam int OAW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [31:0]    num_init_steps = '0, num_train_steps = '0;
  logic [31:0]    num_test_samples = '0, num_steps_per_sample = '0;
  logic           busy, done, reservoir_en, history_wen, dp_start, output_mem_wen;
  logic [IMW-1:0] input_mem_addr;
  logic [HAW-1:0] history_addr, dp_base_addr;
  logic [OAW-1:0] output_mem_addr;
  logic [DW-1:0]  output_mem_data;
  logic           dp_done = 1'b0;
  logic [DW-1:0]  dp_result = '0;

  dfr_core_controller #(
    .RESERVOIR_DATA_WIDTH(DW), .RESERVOIR_HISTORY_ADDR_WIDTH(HAW),
    .INPUT_MEM_ADDR_WIDTH(IMW), .OUTPUT_MEM_ADDR_WIDTH(OAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_init_steps(num_init_steps), .num_train_steps(num_train_steps),
    .num_test_samples(num_test_samples), .num_steps_per_sample(num_steps_per_sample),
    .busy(busy), .done(done), .input_mem_addr(input_mem_addr),
    .reservoir_en(reservoir_en), .history_wen(history_wen), .history_addr(history_addr),
    .dp_start(dp_start), .dp_base_addr(dp_base_addr), .dp_done(dp_done), .dp_result(dp_result),
    .output_mem_wen(output_mem_wen), .output_mem_addr(output_mem_addr),
    .output_mem_data(output_mem_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IMW-1:0] ia; logic wen; logic [HAW-1:0] ha; } step_t;
  typedef struct packed { logic [OAW-1:0] a; logic [DW-1:0] d; } out_t;

  step_t         exp_step[$];
  logic [HAW-1:0] exp_base[$];
  out_t          exp_out[$];
  logic [DW-1:0] res_q[$];
  int            errors = 0, checks = 0;
  int            done_seen = 0, exp_done = 0;
  int            dp_lat = 5;
  step_t         m_step;
  out_t          m_out;
  logic [HAW-1:0] m_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic step_t mk_step(input int g, input logic w, input int h);
    step_t s;
    s.ia  = IMW'(g % (1 << IMW));
    s.wen = w;
    s.ha  = HAW'(h);
    return s;
  endfunction

  // Monitor: every strobe the DUT raises must match the head of its queue.
  always @(negedge clk) begin
    if (reservoir_en) begin
      if (exp_step.size() == 0) chk("unexpected_reservoir_en", 32'd1, 32'd0);
      else begin
        m_step = exp_step.pop_front();
        chk("input_mem_addr", 32'(input_mem_addr), 32'(m_step.ia));
        chk("history_wen", 32'(history_wen), 32'(m_step.wen));
        if (m_step.wen) chk("history_addr", 32'(history_addr), 32'(m_step.ha));
      end
    end
    if (history_wen) chk("history_wen_without_en", 32'(reservoir_en), 32'd1);
    if (dp_start) begin
      if (exp_base.size() == 0) chk("unexpected_dp_start", 32'd1, 32'd0);
      else begin
        m_base = exp_base.pop_front();
        chk("dp_base_addr", 32'(dp_base_addr), 32'(m_base));
      end
    end
    if (output_mem_wen) begin
      if (exp_out.size() == 0) chk("unexpected_output_wen", 32'd1, 32'd0);
      else begin
        m_out = exp_out.pop_front();
        chk("output_mem_addr", 32'(output_mem_addr), 32'(m_out.a));
        chk("output_mem_data", output_mem_data, m_out.d);
      end
    end
    if (done) begin
      done_seen++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  end

  // Dot-product engine stand-in: answers each launch after dp_lat cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (dp_start) begin
        repeat (dp_lat - 1) @(posedge clk);
        #1;
        dp_done   = 1'b1;
        dp_result = (res_q.size() > 0) ? res_q.pop_front() : '0;
        @(posedge clk); #1;
        dp_done = 1'b0;
      end
    end
  end

  task automatic launch(input int ni, input int nt, input int ns, input int np,
                        input int lat, input bit rnd);
    int g, h;
    logic [31:0] r;
    out_t o;
    g = 0;
    h = 0;
    dp_lat = lat;
    num_init_steps = 32'(ni);
    num_train_steps = 32'(nt);
    num_test_samples = 32'(ns);
    num_steps_per_sample = 32'(np);
    for (int i = 0; i < ni; i++) begin exp_step.push_back(mk_step(g, 1'b0, h)); g++; end
    for (int i = 0; i < nt; i++) begin exp_step.push_back(mk_step(g, 1'b1, h)); g++; h++; end
    if (ns > 0 && np > 0) begin
      for (int s = 0; s < ns; s++) begin
        exp_base.push_back(HAW'(h));
        for (int k = 0; k < np; k++) begin exp_step.push_back(mk_step(g, 1'b1, h)); g++; h++; end
        r = rnd ? $urandom : 32'((s + 1) * 17);
        res_q.push_back(r);
        o.a = OAW'(s);
        o.d = r;
        exp_out.push_back(o);
      end
    end
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    exp_done++;
    while (done_seen < exp_done && n < 3000) begin @(posedge clk); #1; n++; end
    chk({name, "_done_count"}, 32'(done_seen), 32'(exp_done));
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_steps_left"}, 32'(exp_step.size()), 32'd0);
    chk({name, "_launches_left"}, 32'(exp_base.size()), 32'd0);
    chk({name, "_writes_left"}, 32'(exp_out.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    if (n >= 3000) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_step.delete(); exp_base.delete(); exp_out.delete(); res_q.delete();
      done_seen = exp_done;
    end
  endtask

  int busy_cnt;
  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reservoir_en", 32'(reservoir_en), 32'd0);
    chk("rst_history_wen", 32'(history_wen), 32'd0);
    chk("rst_dp_start", 32'(dp_start), 32'd0);
    chk("rst_output_mem_wen", 32'(output_mem_wen), 32'd0);
    chk("rst_input_mem_addr", 32'(input_mem_addr), 32'd0);
    chk("rst_history_addr", 32'(history_addr), 32'd0);
    chk("rst_dp_base_addr", 32'(dp_base_addr), 32'd0);
    chk("rst_output_mem_data", output_mem_data, 32'd0);
    rst = 1'b0;

    // Directed run 1 with first-step latency check.
    launch(4, 0, 2, 3, 5, 1'b0);
    @(posedge clk); #1;
    chk("t1_busy_after_edge", 32'(busy), 32'd1);
    chk("t1_no_en_yet", 32'(reservoir_en), 32'd0);
    @(posedge clk); #1;
    chk("t1_first_en", 32'(reservoir_en), 32'd1);
    wait_done("t1");

    launch(2, 3, 1, 2, 4, 1'b0);
    wait_done("t2");

    // Empty run: busy for a single cycle, then done.
    launch(0, 0, 0, 0, 2, 1'b0);
    exp_done++;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (busy) busy_cnt++; end
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd1);
    chk("t3_done_count", 32'(done_seen), 32'(exp_done));

    // start still held high: no re-trigger until a fresh edge.
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (busy) busy_cnt++; end
    chk("t4_held_start_busy", 32'(busy_cnt), 32'd0);
    chk("t4_held_start_done", 32'(done_seen), 32'(exp_done));
    launch(3, 2, 2, 2, 3, 1'b1);
    wait_done("t4_rerun");

    // Reset while waiting on the dot-product engine.
    launch(1, 0, 1, 2, 20, 1'b1);
    n = 0;
    while (!dp_start && n < 200) begin @(posedge clk); #1; n++; end
    chk("t5_dp_start_seen", 32'(dp_start), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_reservoir_en", 32'(reservoir_en), 32'd0);
    chk("t5_rst_history_wen", 32'(history_wen), 32'd0);
    chk("t5_rst_dp_start", 32'(dp_start), 32'd0);
    chk("t5_rst_output_mem_wen", 32'(output_mem_wen), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    exp_out.delete();
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (busy) busy_cnt++; end
    chk("t5_stray_dp_done_consumed", 32'(res_q.size()), 32'd0);
    chk("t5_idle_after_rst", 32'(busy_cnt), 32'd0);
    chk("t5_no_done", 32'(done_seen), 32'(exp_done));
    launch(2, 1, 2, 3, 2, 1'b1);
    wait_done("t5_after");

    // Input address wraps at 2^IMW.
    launch(20, 0, 0, 0, 2, 1'b0);
    wait_done("t6_wrap");

    for (int i = 0; i < 8; i++) begin
      launch(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
             int'($urandom_range(2, 7)), 1'b1);
      wait_done("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dfr_core_controller.md
Name: dfr_core_controller

Overview:
- Run sequencer for the DFR core. Steps the reservoir through three phases: INIT, TRAIN and TEST.
- Produces input-memory read addresses, reservoir step enables and reservoir-history write addresses.
- After each TEST sample it launches the weight dot-product engine and writes the result to output memory.
- Sits between the AXI config registers (start, counts) and the reservoir, dot-product and memory datapath.

Parameters:
RESERVOIR_DATA_WIDTH, 32, width of the dot-product result and output-memory data.
RESERVOIR_HISTORY_ADDR_WIDTH, 16, width of the history address.
INPUT_MEM_ADDR_WIDTH, 16, width of the input-memory word address.
OUTPUT_MEM_ADDR_WIDTH, 16, width of the output-memory word address.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  CTRL_REG bit0, level; a run is triggered on its 0->1 edge.
num_init_steps  in  32  reservoir steps in INIT.
num_train_steps  in  32  reservoir steps in TRAIN.
num_test_samples  in  32  number of TEST samples.
num_steps_per_sample  in  32  reservoir steps per sample.
busy  out  1  high from the cycle after the start edge until DONE.
done  out  1  one-cycle pulse on run completion.
input_mem_addr  out  INPUT_MEM_ADDR_WIDTH  input sample address for the current step.
reservoir_en  out  1  advance the reservoir one step.
history_wen  out  1  write the reservoir output to history.
history_addr  out  RESERVOIR_HISTORY_ADDR_WIDTH  history write address.
dp_start  out  1  one-cycle dot-product launch.
dp_base_addr  out  RESERVOIR_HISTORY_ADDR_WIDTH  history address of the sample's first step.
dp_done  in  1  dot-product result valid (pulse).
dp_result  in  RESERVOIR_DATA_WIDTH  dot-product result.
output_mem_wen  out  1  output-memory write strobe.
output_mem_addr  out  OUTPUT_MEM_ADDR_WIDTH  output index (test sample number).
output_mem_data  out  RESERVOIR_DATA_WIDTH  registered dp_result.

Behaviour:
- Reset: state=IDLE. All outputs 0 and all counters 0. start_d=0.
- start_d is a registered copy of start. The edge is start & ~start_d, honoured only in IDLE and ignored otherwise.
- Counters:
  - gstep (32b): global step count, never cleared within a run.
  - pstep: steps done in the current phase.
  - sstep: step within the current sample.
  - hptr: history pointer.
  - samp: test sample index.
- input_mem_addr = gstep[INPUT_MEM_ADDR_WIDTH-1:0]. history_addr = hptr. Both wrap modulo 2^width.
- IDLE: on edge, clear all counters and set busy=1. Next state is the first non-empty phase, in order INIT (num_init_steps>0), TRAIN (num_train_steps>0), TEST (num_test_samples>0 and num_steps_per_sample>0); otherwise DONE.
- INIT: each cycle reservoir_en=1, history_wen=0; gstep++, pstep++. On the cycle where pstep==num_init_steps-1, go to the next non-empty phase and clear pstep.
- TRAIN: as INIT, plus history_wen=1 and hptr++. Exits after num_train_steps.
- TEST:
  - Each cycle reservoir_en=1, history_wen=1; gstep++, hptr++, sstep++.
  - At sstep==0, latch dp_base_addr=hptr.
  - On the cycle where sstep==num_steps_per_sample-1, go to DP_START and clear sstep.
- DP_START: dp_start=1 for exactly one cycle, reservoir_en=0. Then go to DP_WAIT.
- DP_WAIT:
  - Hold all strobes low until dp_done.
  - On dp_done, register output_mem_data=dp_result and output_mem_addr=samp; go to OUT_WR.
  - dp_done arriving in the same cycle as DP_START is ignored. Wait is unbounded; only rst exits.
- OUT_WR: output_mem_wen=1 for one cycle, samp++. If samp==num_test_samples-1 go to DONE, else go to TEST.
- DONE: done=1 for one cycle, busy drops to 0 in that same cycle, go to IDLE. Counters keep their values until the next start.
- Strobes (reservoir_en, history_wen, dp_start, output_mem_wen, done) are registered outputs, valid the cycle after the state decision. The first reservoir_en appears 2 cycles after the start edge cycle (1 cycle for edge detect, 1 for the registered output).
- Config inputs are sampled continuously; software must not change them while busy. Behaviour under a mid-run change is undefined but must not lock up beyond the DP_WAIT rule.
- rst mid-run: next cycle all outputs 0, state=IDLE. A start held high through reset does not re-trigger, because start_d loads start on reset release and a new 0->1 edge is required.
- Step-count totals: INIT steps + TRAIN steps + test_samples*steps_per_sample reservoir_en pulses per run, no gaps except the DP_START/DP_WAIT/OUT_WR bubbles.

Test Plan:
1. init=4, train=0, test_samples=2, steps=3, dp_done 5 cycles after dp_start with result 0x11/0x22:
   - 10 reservoir_en pulses, input_mem_addr 0..9.
   - history_wen only on steps 4..9, history_addr 0..5.
   - dp_base_addr 0 then 3.
   - Output writes addr0=0x11, addr1=0x22.
   - One done pulse.
2. init=2, train=3, test_samples=1, steps=2:
   - history_addr 0..4 across TRAIN+TEST.
   - dp_base_addr=3.
   - One output write at addr 0.
3. All counts 0, start edge -> busy one cycle, done pulse, no reservoir_en/output writes.
4. start held high after run completes -> no second run; start toggled 0->1 -> second run with counters restarted at 0.
5. rst asserted during DP_WAIT -> next cycle busy=0, all strobes 0, a later dp_done is ignored, a new start edge runs cleanly.
6. Wrap: INPUT_MEM_ADDR_WIDTH=4, init=20 -> input_mem_addr sequence 0..15,0..3.
